// File: rtl/movavg_pkg.sv
// Shared definitions for the bit-serial 4-tap moving-sum block.
// Holds the word width, the bit-counter width and the sequencer state
// encoding. The sequencer, the deserializer, the datapath and the bench
// all import it.
package movavg_pkg;

  // Word width in bits (power of two, at least 4)
  localparam int W  = 64;
  // Bit-counter width, log2(W)
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPT,
    OUT
  } state_e;

endpackage

// File: rtl/movavg_deser.sv
// Serial-to-parallel collector for the moving-sum datapath output.
// The datapath registers its sum bit, so each bit arrives one cycle after
// the dp_en that produced it. A one-register delay of dp_en (r_cap_en)
// marks the cycles that carry a valid sum bit.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_dp_en   datapath enable strobe from the sequencer
//   i_dp_sum  serial sum bit from the datapath, LSB first
//   o_word    assembled word: the live sum bit on top of the collected bits
//
// o_word is complete in the cycle that carries the last sum bit. The
// sequencer latches it on that edge without waiting another cycle.
module movavg_deser
  import movavg_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_dp_en,
  input  logic         i_dp_sum,
  output logic [W-1:0] o_word
);

  logic         r_cap_en;
  logic [W-2:0] r_col;
  logic [W-1:0] w_word;

  // Only W-1 bits need storing. The top bit is the sum bit arriving in the
  // capture cycle itself.
  assign w_word = {i_dp_sum, r_col};
  assign o_word = w_word;

  // Bits enter at the top and move down, so after W-1 shifts bit 0 of the
  // sum sits in r_col[0].
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap_en <= 1'b0;
      r_col    <= '0;
    end else begin
      r_cap_en <= i_dp_en;
      if (r_cap_en) begin
        r_col <= w_word[W-1:1];
      end
    end
  end

endmodule

// File: rtl/movavg_seq.sv
// Sequencer for the bit-serial 4-tap moving-sum datapath.
// The block takes a parallel word on a valid/ready handshake and shifts it
// into the datapath LSB first. It drives the carry-clear (first),
// enable and tap-advance (last) strobes. It gathers the serial sum back into
// a parallel word and holds that word on a valid/ready output until it is
// taken.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   i_in_data is valid
//   o_in_ready   block can accept a word (IDLE only)
//   i_in_data    parallel input word
//   o_out_valid  o_out_data holds a completed sum
//   i_out_ready  consumer accepts o_out_data
//   o_out_data   sum of the last four inputs mod 2^W
//   o_dp_en      datapath processes one bit this cycle
//   o_dp_bit     serial input bit to the datapath
//   o_dp_first   bit 0 of the word; datapath clears its carries
//   o_dp_last    bit W-1 of the word; datapath advances its taps
//   i_dp_sum     registered serial sum bit from the datapath
//   o_busy       sequencer is not idle
//
// Timing: the accept edge is edge 0. Bits go out in cycles 1..W. The result
// is latched at edge W+1. The word is released on the first edge with
// i_out_ready high. A new word can be accepted one cycle later, so the
// minimum word period is W+3 cycles.
module movavg_seq
  import movavg_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_dp_en,
  output logic         o_dp_bit,
  output logic         o_dp_first,
  output logic         o_dp_last,
  input  logic         i_dp_sum,
  output logic         o_busy
);

  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [W-1:0]  r_shreg;
  logic [CW-1:0] r_bitcnt;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [W-1:0]  w_word;
  logic          w_last;

  assign w_last = (r_bitcnt == LAST_BIT);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode. The dp_* strobes depend only on the
  // registered state, counter and shift register. They carry no path from
  // i_in_valid or i_out_ready.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_dp_en     = 1'b0;
    o_dp_bit    = 1'b0;
    o_dp_first  = 1'b0;
    o_dp_last   = 1'b0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        o_dp_en    = 1'b1;
        o_dp_bit   = r_shreg[0];
        o_dp_first = (r_bitcnt == '0);
        o_dp_last  = w_last;
        if (w_last) begin
          w_state_nxt = CAPT;
        end
      end
      CAPT: begin
        w_state_nxt = OUT;
      end
      OUT: begin
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Input shift register, bit counter and output holding register.
  // The counter returns to zero on the SHIFT exit, so it never runs past
  // W-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_shreg  <= i_in_data;
            r_bitcnt <= '0;
          end
        end
        SHIFT: begin
          r_shreg  <= r_shreg >> 1;
          r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
        end
        CAPT: begin
          r_out_data  <= w_word;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  movavg_deser u_deser (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_dp_en  (o_dp_en),
    .i_dp_sum (i_dp_sum),
    .o_word   (w_word)
  );

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_movavg_seq.sv
// Bench for movavg_seq. The bench plays the datapath with one of two models:
// a loopback (the sum bit is the registered input bit) or a bit-serial 4-tap
// adder. It checks the results against hand-computed values and against a
// word-level running sum of the last four inputs.
module tb_movavg_seq;
  import movavg_pkg::*;

  logic         clk;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] inData;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] outData;
  logic         dpEn;
  logic         dpBit;
  logic         dpFirst;
  logic         dpLast;
  logic         dpSum;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic         adderMode = 1'b0;
  logic         dpClr     = 1'b0;
  logic [W-1:0] p1, p2, p3, cur;
  logic [1:0]   carry;
  int           k;

  movavg_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in_data   (inData),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_data  (outData),
    .o_dp_en     (dpEn),
    .o_dp_bit    (dpBit),
    .o_dp_first  (dpFirst),
    .o_dp_last   (dpLast),
    .i_dp_sum    (dpSum),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model. The taps survive a sequencer reset, just like the real
  // datapath. Only dpClr empties them.
  always @(posedge clk) begin
    int kk;
    logic [2:0] s;
    if (dpClr) begin
      p1 <= '0; p2 <= '0; p3 <= '0; cur <= '0;
      carry <= '0; k <= 0; dpSum <= 1'b0;
    end else if (dpEn) begin
      if (!adderMode) begin
        dpSum <= dpBit;
      end else begin
        kk = dpFirst ? 0 : k;
        s = 3'(dpBit) + 3'(p1[kk]) + 3'(p2[kk]) + 3'(p3[kk])
            + (dpFirst ? 3'd0 : 3'(carry));
        dpSum   <= s[0];
        carry   <= s[2:1];
        cur[kk] <= dpBit;
        k       <= kk + 1;
        if (dpLast) begin
          p3 <= p2;
          p2 <= p1;
          p1 <= {dpBit, cur[W-2:0]};
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clearTaps(input logic mode);
    @(negedge clk);
    adderMode = mode;
    dpClr = 1'b1;
    @(negedge clk);
    dpClr = 1'b0;
  endtask

  // Sends one word from IDLE and waits (bounded) for its result, then
  // releases it. Ends in IDLE.
  task automatic applyStimulus(input logic [W-1:0] din, output logic [W-1:0] dout);
    int n;
    @(negedge clk);
    inValid = 1'b1;
    inData  = din;
    @(negedge clk);
    inValid = 1'b0;
    inData  = {$urandom, $urandom};
    n = 0;
    while (!outValid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!outValid) checkOutput("word_timeout", W'(outValid), W'(1));
    dout = outData;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] held;
    logic [W-1:0] sumIn  [5];
    logic [W-1:0] sumExp [5];
    logic [W-1:0] wrapExp[4];
    int firstCnt, firstCyc, lastCnt, lastCyc, enCnt, validEdge;
    int bpValid, bpReady, bpEn, bpChanged;

    rstN = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    dpClr = 1'b1;

    // Reset values while reset is held
    #12;
    checkOutput("rst_in_ready",  W'(inReady),  W'(1));
    checkOutput("rst_busy",      W'(busy),     W'(0));
    checkOutput("rst_out_valid", W'(outValid), W'(0));
    checkOutput("rst_out_data",  outData,      '0);
    checkOutput("rst_dp",        W'({dpEn, dpBit, dpFirst, dpLast}), W'(0));
    @(negedge clk);
    rstN = 1'b1;
    dpClr = 1'b0;

    // Timing with loopback: strobe positions and result latency
    clearTaps(1'b0);
    @(negedge clk);
    inValid = 1'b1;
    inData  = 64'h1;
    firstCnt = 0; firstCyc = 0; lastCnt = 0; lastCyc = 0; enCnt = 0; validEdge = -1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) inValid = 1'b0;
      if (dpFirst) begin firstCnt++; firstCyc = c; end
      if (dpLast)  begin lastCnt++;  lastCyc  = c; end
      if (dpEn) enCnt++;
      if (outValid && validEdge < 0) validEdge = c - 1;
    end
    checkOutput("first_count", W'(firstCnt), W'(1));
    checkOutput("first_cycle", W'(firstCyc), W'(1));
    checkOutput("last_count",  W'(lastCnt),  W'(1));
    checkOutput("last_cycle",  W'(lastCyc),  W'(64));
    checkOutput("en_count",    W'(enCnt),    W'(64));
    checkOutput("valid_edge",  W'(validEdge), W'(65));
    checkOutput("loop_data",   outData,      64'h1);

    // Backpressure: still in OUT with outReady low
    held = outData;
    bpValid = 0; bpReady = 0; bpEn = 0; bpChanged = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (outValid) bpValid++;
      if (inReady) bpReady++;
      if (dpEn) bpEn++;
      if (outData !== held) bpChanged++;
    end
    checkOutput("bp_valid",    W'(bpValid),   W'(10));
    checkOutput("bp_in_ready", W'(bpReady),   W'(0));
    checkOutput("bp_dp_en",    W'(bpEn),      W'(0));
    checkOutput("bp_data",     W'(bpChanged), W'(0));
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("xfer_valid",    W'(outValid), W'(0));
    checkOutput("xfer_in_ready", W'(inReady),  W'(1));
    checkOutput("xfer_busy",     W'(busy),     W'(0));

    // Reset in the middle of SHIFT, at bit 20
    @(negedge clk);
    inValid = 1'b1;
    inData  = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    inValid = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("mid_pre_en", W'(dpEn), W'(1));
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("mid_busy",      W'(busy),     W'(0));
    checkOutput("mid_in_ready",  W'(inReady),  W'(1));
    checkOutput("mid_dp",        W'({dpEn, dpBit, dpFirst, dpLast}), W'(0));
    checkOutput("mid_out_valid", W'(outValid), W'(0));
    checkOutput("mid_out_data",  outData,      '0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(64'h0123_4567_89AB_CDEF, res);
    checkOutput("mid_after", res, 64'h0123_4567_89AB_CDEF);

    // Moving sums with the 4-tap model
    clearTaps(1'b1);
    sumIn  = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
    sumExp = '{64'd1, 64'd3, 64'd6, 64'd10, 64'd14};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(sumIn[i], res);
      checkOutput($sformatf("sum_%0d", i), res, sumExp[i]);
    end

    // Modulo wrap with all-ones inputs
    clearTaps(1'b1);
    wrapExp = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, res);
      checkOutput($sformatf("wrap_%0d", i), res, wrapExp[i]);
    end

    // Continuous stream with in_valid and out_ready held high
    clearTaps(1'b1);
    begin
      logic [W-1:0] h0, h1, h2, h3;
      logic [W-1:0] expQ[$];
      int accepted, results, lastCyc2;
      logic newData;
      h0 = '0; h1 = '0; h2 = '0; h3 = '0;
      accepted = 0; results = 0; lastCyc2 = 0; newData = 1'b0;
      @(negedge clk);
      inValid  = 1'b1;
      outReady = 1'b1;
      inData   = {$urandom, $urandom};
      for (int n = 0; n < 1024 * 67 + 400 && results < 1024; n++) begin
        if (inValid && inReady) begin
          h3 = h2; h2 = h1; h1 = h0; h0 = inData;
          expQ.push_back(h0 + h1 + h2 + h3);
          accepted++;
          newData = 1'b1;
        end
        if (outValid) begin
          if (expQ.size() == 0) begin
            checkOutput("stream_unexpected", outData, '0);
          end else begin
            checkOutput("stream_sum", outData, expQ.pop_front());
          end
          if (results > 0) checkOutput("stream_period", W'(cyc - lastCyc2), W'(67));
          lastCyc2 = cyc;
          results++;
        end
        @(negedge clk);
        if (newData) begin
          newData = 1'b0;
          inData  = {$urandom, $urandom};
          if (accepted >= 1024) inValid = 1'b0;
        end
      end
      checkOutput("stream_count", W'(results), W'(1024));
      inValid  = 1'b0;
      outReady = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/movavg_seq.md
Name: movavg_seq

Overview:
- Sequencer for the bit-serial 4-tap moving-sum datapath (`movavg` core).
- Accepts parallel 64-bit words on a valid/ready handshake and serializes each word LSB-first into the datapath.
- Drives the datapath carry-clear, enable and tap-advance strobes.
- Collects the serial sum back into a parallel word and presents it on a valid/ready output.
- Replaces testbench-driven timing with an explicit protocol at the top level.

Parameters:
- W, 64, word width in bits (power of two, ≥4).
- CW, 6, bit-counter width, equal to log2(W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a word; transfer happens on an edge where in_valid && in_ready.
- in_data  in  W  parallel input word.
- out_valid  out  1  out_data holds a completed sum.
- out_ready  in  1  consumer accepts out_data; transfer happens on an edge where out_valid && out_ready.
- out_data  out  W  parallel result, sum of last 4 inputs mod 2^W.
- dp_en  out  1  datapath processes one bit this cycle.
- dp_bit  out  1  serial input bit to datapath, LSB first.
- dp_first  out  1  bit 0 of word; datapath clears its carries.
- dp_last  out  1  bit W-1 of word; datapath advances taps at the end of this cycle.
- dp_sum  in  1  serial sum bit from datapath, registered there, valid one cycle after its dp_en.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, SHIFT, CAPT, OUT.
- Reset (reset=0, async): state=IDLE, shift reg=0, collector=0, bitcnt=0, out_valid=0, out_data=0, dp_en/dp_bit/dp_first/dp_last=0, busy=0. in_ready=1 during reset.
- IDLE:
  - in_ready=1, all dp_* = 0.
  - On an accept edge (call it edge 0): shreg<=in_data, bitcnt<=0, go to SHIFT.
- SHIFT (W cycles, edges 0..W):
  - dp_en=1; dp_bit=shreg[0]; dp_first=(bitcnt==0); dp_last=(bitcnt==W-1).
  - Each edge: shreg>>=1, bitcnt++.
  - On the edge where bitcnt==W-1, go to CAPT.
- Capture path:
  - cap_en = dp_en delayed by one register.
  - When cap_en=1: col <= {dp_sum, col[W-1:1]}.
- CAPT (1 cycle):
  - dp_en=0; the last bit is captured at edge W+1.
  - At edge W+1: out_data<=assembled word, out_valid<=1, go to OUT.
- OUT:
  - out_valid=1; out_data is stable until transfer.
  - On the edge where out_ready=1: out_valid<=0, go to IDLE.
- Latency and throughput:
  - out_valid rises W+1 edges after the accept edge (65 for W=64).
  - Minimum word period is W+3 cycles (67).
- in_ready=0 in SHIFT, CAPT and OUT; in_valid is ignored there and in_data need not be held.
- out_ready is ignored when out_valid=0.
- Glitch-free outputs:
  - dp_* are combinational from registered state, bitcnt and shreg only.
  - There is no combinational path from in_valid or out_ready to any output.
- Arithmetic: the sequencer performs no arithmetic. Modulo-2^W wrap is the datapath's responsibility; carries are cleared at dp_first, so nothing crosses word boundaries.
- bitcnt wraps W-1→0 only at the SHIFT exit and never exceeds W-1.
- Reset mid-operation:
  - Any state returns to IDLE immediately and the partial word is discarded.
  - The datapath tap contents are not cleared by this block.
- Simultaneous events: in_valid arriving while out_valid=1 and out_ready=1 is not accepted until the cycle after the return to IDLE.

Decomposition:
- movavg_pkg holds W, CW, and the state enum {IDLE, SHIFT, CAPT, OUT}; the datapath and bench share it.
- One sub-module, movavg_deser: the W-bit serial-to-parallel collector with its cap_en delay register.
- The FSM, bitcnt and input shift register stay in movavg_seq.

Test Plan:
- Reset: assert reset at bit 20 of SHIFT → outputs immediately at reset values, in_ready=1, busy=0. After release, the next word processes normally.
- Timing: loopback model (dp_sum = registered dp_bit), in_data=0x0000_0000_0000_0001 → dp_first only in cycle 1, dp_last only in cycle 64, out_valid at edge 65, out_data=0x1.
- Sums: 4-tap serial adder model, inputs 1,2,3,4,5 → out_data 1,3,6,10,14.
- Wrap: 4-tap model, four inputs of 0xFFFF_FFFF_FFFF_FFFF → fourth out_data=0xFFFF_FFFF_FFFF_FFFC.
- Backpressure: hold out_ready=0 for 10 cycles in OUT → out_valid=1 and out_data stable, in_ready=0, dp_en=0. Raise out_ready → transfer, then in_ready=1 the following cycle.
- Stream: in_valid=1, out_ready=1, 1024 random words with a 4-tap model → every out_data equals the sum of the last 4 inputs mod 2^64, one result per 67 cycles.
